// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                             |
// | Description : Shares one combinational ALU among NREQ requesters using      |
// |               request/response handshakes and registered ALU operands.      |
// |               Define ALU_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.|
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module alu_share_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [3:0]           alu_control,
    output logic [31:0]          alu_src_a,
    output logic [31:0]          alu_src_b,
    input  logic [31:0]          alu_result,
    output logic                 busy
);

    localparam int c_idxW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                w_accept;
    logic                w_anyValid;
    logic [c_idxW-1:0]   w_grant;
    logic [c_idxW-1:0]   r_owner;
    logic [3:0]          r_op;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_rspData;
    logic [3:0]          w_selOp;
    logic [31:0]         w_selA;
    logic [31:0]         w_selB;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        w_grant    = '0;
        w_anyValid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[c_idxW'(i)]) begin
                w_grant    = c_idxW'(i);
                w_anyValid = 1'b1;
            end
        end
    end
`else
    logic [c_idxW-1:0] r_last;

    // Scan from farthest to nearest after r_last; the nearest valid wins.
    always_comb begin
        int idx;
        w_grant    = '0;
        w_anyValid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NREQ;
            if (req_valid[c_idxW'(idx)]) begin
                w_grant    = c_idxW'(idx);
                w_anyValid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= c_idxW'(NREQ - 1);
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`endif

    always_comb begin
        w_selOp = '0;
        w_selA  = '0;
        w_selB  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == c_idxW'(i)) begin
                w_selOp = req_op[4*i +: 4];
                w_selA  = req_a[32*i +: 32];
                w_selB  = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_stateNext = EXEC;
                    w_accept    = 1'b1;
                end
            end
            EXEC:    w_stateNext = RESP;
            RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rspData <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_owner <= w_grant;
                r_op    <= w_selOp;
                r_a     <= w_selA;
                r_b     <= w_selB;
            end
            if (r_state == EXEC) begin
                r_rspData <= alu_result;
            end
        end
    end

    // Ready is gated by resetn so it reads 0 while reset is held.
    assign req_ready   = (r_state == IDLE && w_anyValid && resetn) ? (NREQ'(1) << w_grant) : '0;
    assign rsp_valid   = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
    assign rsp_data    = r_rspData;
    assign alu_control = r_op;
    assign alu_src_a   = r_a;
    assign alu_src_b   = r_b;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                          |
// | Description : Scoreboard bench for alu_share_arbiter with a small ALU model.|
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_alu_share_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_data;
    logic [3:0]          alu_control;
    logic [31:0]         alu_src_a;
    logic [31:0]         alu_src_b;
    logic [31:0]         alu_result;
    logic                busy;

    int nChecks = 0;
    int nErrors = 0;
    int expReq[$];
    logic [31:0] expData[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_control(alu_control),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_result (alu_result),
        .busy       (busy)
    );

    // Minimal ALU: ADD, SUB, AND, OR; anything else returns 0.
    always_comb begin
        case (alu_control)
            4'h0:    alu_result = alu_src_a + alu_src_b;
            4'h1:    alu_result = alu_src_a - alu_src_b;
            4'h2:    alu_result = alu_src_a & alu_src_b;
            4'h3:    alu_result = alu_src_a | alu_src_b;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        int r;
        logic [31:0] d;
        if (resetn === 1'b1 && rsp_valid != '0) begin
            chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
            if ((rsp_valid & rsp_ready) != '0) begin
                if (expData.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    r = expReq.pop_front();
                    d = expData.pop_front();
                    chk("rsp_owner", 32'(rsp_valid), 32'(1 << r));
                    chk("rsp_data", rsp_data, d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[r]       = 1'b1;
        req_op[4*r +: 4]   = op;
        req_a[32*r +: 32]  = a;
        req_b[32*r +: 32]  = b;
    endtask

    task automatic expectRsp(input int r, input logic [31:0] d);
        expReq.push_back(r);
        expData.push_back(d);
    endtask

    task automatic waitGrant(output int g);
        g = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                break;
            end
        end
        if (g < 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL grant_timeout: got no req_ready expected a grant at %0t", $time);
        end
    endtask

    // Wait for a grant, check it, queue its response and drop that valid after the handshake.
    task automatic grantAndClear(input int expG, input logic [31:0] expD);
        int g;
        waitGrant(g);
        chk("grant", 32'(g), 32'(expG));
        expectRsp(expG, expD);
        tick();
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_src_a", alu_src_a, 32'd0);
        chk("rst_src_b", alu_src_b, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Contention: both held valid, grants rotate 0 then 1, twice.
        setReq(0, 4'h1, 32'd10, 32'd3);
        setReq(1, 4'h3, 32'hF0, 32'h0F);
        grantAndClear(0, 32'd7);
        grantAndClear(1, 32'hFF);
        repeat (3) tick();
        setReq(0, 4'h2, 32'hFF, 32'h0F);
        setReq(1, 4'h0, 32'd1, 32'd2);
        grantAndClear(0, 32'h0F);
        grantAndClear(1, 32'd3);
        repeat (3) tick();

        // Single op with cycle-exact latency.
        setReq(0, 4'h0, 32'd5, 32'd7);
        expectRsp(0, 32'd12);
        @(negedge clk);
        chk("single_req_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("single_exec_ctrl", 32'(alu_control), 32'd0);
        chk("single_exec_a", alu_src_a, 32'd5);
        chk("single_exec_b", alu_src_b, 32'd7);
        chk("single_exec_busy", 32'(busy), 32'd1);
        chk("single_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("single_rsp_data", rsp_data, 32'd12);
        tick();

        // Backpressure: response held for 5 cycles while requester 0 waits.
        rsp_ready = '0;
        setReq(1, 4'h0, 32'd100, 32'd23);
        grantAndClear(1, 32'd123);
        setReq(0, 4'h0, 32'd1, 32'd1);
        expectRsp(0, 32'd2);
        @(negedge clk);
        chk("bp_exec_req_ready", 32'(req_ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b10);
            chk("bp_rsp_data", rsp_data, 32'd123);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = '1;
        tick();
        @(negedge clk);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid[0] = 1'b0;
        repeat (3) tick();

        // Reset during EXEC discards the op.
        setReq(0, 4'h1, 32'd9, 32'd4);
        begin
            int g;
            waitGrant(g);
            chk("rstmid_grant", 32'(g), 32'd0);
        end
        tick();
        resetn = 1'b0;
        #1;
        chk("rstmid_req_ready", 32'(req_ready), 32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_rsp_data", rsp_data, 32'd0);
        chk("rstmid_alu_control", 32'(alu_control), 32'd0);
        chk("rstmid_src_a", alu_src_a, 32'd0);
        chk("rstmid_src_b", alu_src_b, 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        req_valid[0] = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();

        // Unchecked op 4'b1111 returns whatever the ALU gives (0).
        setReq(1, 4'hF, 32'd3, 32'd4);
        grantAndClear(1, 32'd0);
        @(negedge clk);
        chk("inv_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("inv_exec_ctrl", 32'(alu_control), 32'hF);
        tick();
        @(negedge clk);
        chk("inv_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("inv_rsp_data", rsp_data, 32'd0);
        repeat (3) tick();

`ifdef ALU_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 continuously valid starves requester 1.
        setReq(1, 4'h0, 32'd7, 32'd7);
        for (int i = 0; i < 3; i++) begin
            setReq(0, 4'h0, 32'(i), 32'd1);
            grantAndClear(0, 32'(i + 1));
            repeat (2) tick();
        end
        grantAndClear(1, 32'd14);
        repeat (3) tick();
`endif

        chk("scoreboard_empty", 32'(expData.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
